// File: rtl/calc_display_pkg.sv
// Shared definitions for the calculator display stage: segment codes,
// conversion FSM encoding and the BCD-to-7-segment decoder.
package calc_display_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/calc_display_bin2bcd.sv
// Sequential double-dabble converter: W shift cycles plus one DONE cycle.
// The FSM state is exported on the state port for observation.
module bin2bcd_seq
  import calc_display_pkg::*;
#(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd,
  output state_e          state
);

  localparam int SW = 4*ND + W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state_next;
  logic [SW-1:0] sr;
  logic [SW-1:0] sr_adj;
  logic [CW-1:0] cnt;
  logic          load;

  // A start is accepted from IDLE, and from DONE to chain straight into the next value
  assign load = start && (state != SHIFT);

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < ND; i++) begin
      if (sr[W+4*i +: 4] >= 4'd5) sr_adj[W+4*i +: 4] = sr[W+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        sr  <= {{(4*ND){1'b0}}, bin};
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= sr_adj << 1;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = sr[SW-1 -: 4*ND];

endmodule

// File: rtl/calc_display.sv
// Calculator result display: edge-triggered BCD conversion with a one-deep
// pending slot, and a multiplexed active-low common-anode 7-segment driver.
module calc_display
  import calc_display_pkg::*;
#(
  parameter int W        = 8,
  parameter int ND       = 3,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [W-1:0]  data,
  output logic          busy,
  output logic [6:0]    seg,
  output logic [ND-1:0] an
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(ND - 1);

  // ready is a level valid for data; each 0->1 transition seen after reset
  // offers one new result. There is no back-pressure: data arriving while the
  // engine is busy waits in the pending slot, and a newer one replaces it.
  logic            ready_q;
  logic            armed;
  logic            start_ev;
  logic            pend;
  logic [W-1:0]    pend_data;
  logic            eng_start;
  logic [W-1:0]    eng_bin;
  logic            eng_done;
  logic [4*ND-1:0] eng_bcd;
  state_e          eng_state;
  logic [4*ND-1:0] disp;
  logic [PW-1:0]   pre;
  logic [IW-1:0]   idx;
  logic            active;
  logic [6:0]      digit_seg;
  logic            lead;
  logic [3:0]      nib;

  // armed keeps a ready level already high at reset release from counting as an edge
  assign start_ev  = ready & ~ready_q & armed;
  assign eng_start = (start_ev & (eng_state == IDLE)) | (eng_done & (start_ev | pend));
  assign eng_bin   = start_ev ? data : pend_data;

  bin2bcd_seq #(.W(W), .ND(ND)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (eng_start),
    .bin   (eng_bin),
    .busy  (busy),
    .done  (eng_done),
    .bcd   (eng_bcd),
    .state (eng_state)
  );

  always_comb begin
    digit_seg = SEG_BLANK;
    lead      = 1'b1;
    nib       = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      nib = disp[4*i +: 4];
      if (nib != 4'd0) lead = 1'b0;
      if (IW'(i) == idx) begin
        digit_seg = ((BLANK != 0) && lead && (i != 0)) ? SEG_BLANK : bcd_to_seg(nib);
      end
    end
    if (!ready_q) digit_seg = SEG_DASH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q   <= 1'b0;
      armed     <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
      disp      <= '0;
      pre       <= '0;
      idx       <= '0;
      active    <= 1'b0;
      seg       <= SEG_BLANK;
      an        <= '1;
    end else begin
      ready_q <= ready;
      if (!ready) armed <= 1'b1;
      if (eng_done) begin
        disp <= eng_bcd;
        pend <= 1'b0;
      end else if (start_ev && (eng_state == SHIFT)) begin
        pend      <= 1'b1;
        pend_data <= data;
      end
      if (pre == PRE_LAST) begin
        pre    <= '0;
        active <= 1'b1;
        idx    <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      // seg and an come from the same idx/active snapshot so they switch together
      an  <= active ? ~(ND'(1) << idx) : '1;
      seg <= active ? digit_seg : SEG_BLANK;
    end
  end

endmodule
